// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with integer pixel repetition and a lookahead fetch port.
// One scan-position engine drives the beam; a second, started PREFETCH pixels ahead, drives the fetch requests.

module vga_scan_pos #(
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int SCALE    = 2,
  parameter int H_INIT   = 0,
  parameter int HW       = 10,
  parameter int VW       = 10,
  parameter int SXW      = 9,
  parameter int SYW      = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           step,
  output logic [HW-1:0]  h,
  output logic [VW-1:0]  v,
  output logic [SXW-1:0] sx,
  output logic [SYW-1:0] sy,
  output logic [HW-1:0]  h_nxt,
  output logic [VW-1:0]  v_nxt,
  output logic           col_start,
  output logic           line_wrap,
  output logic           frame_wrap
);

  localparam int SW     = (SCALE > 1) ? $clog2(SCALE) : 1;
  // Source coordinates saturate at the last active column while the position sits in blanking.
  localparam int X_INIT = (H_INIT < H_ACTIVE) ? H_INIT : H_ACTIVE - 1;

  logic [SW-1:0]  xs, ys, xs_nxt, ys_nxt;
  logic [SXW-1:0] sx_nxt;
  logic [SYW-1:0] sy_nxt;

  assign line_wrap  = step && (int'(h) == H_TOTAL - 1);
  assign frame_wrap = line_wrap && (int'(v) == V_TOTAL - 1);
  assign col_start  = (xs_nxt == '0);

  // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    h_nxt  = h;
    v_nxt  = v;
    sx_nxt = sx;
    sy_nxt = sy;
    xs_nxt = xs;
    ys_nxt = ys;
    if (line_wrap) begin
      h_nxt  = '0;
      sx_nxt = '0;
      xs_nxt = '0;
      if (frame_wrap) begin
        v_nxt  = '0;
        sy_nxt = '0;
        ys_nxt = '0;
      end else begin
        v_nxt = v + 1'b1;
        if (int'(v) < V_ACTIVE - 1) begin
          if (int'(ys) == SCALE - 1) begin
            ys_nxt = '0;
            sy_nxt = sy + 1'b1;
          end else begin
            ys_nxt = ys + 1'b1;
          end
        end
      end
    end else if (step) begin
      h_nxt = h + 1'b1;
      if (int'(h) < H_ACTIVE - 1) begin
        if (int'(xs) == SCALE - 1) begin
          xs_nxt = '0;
          sx_nxt = sx + 1'b1;
        end else begin
          xs_nxt = xs + 1'b1;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h  <= HW'(H_INIT);
      v  <= '0;
      sx <= SXW'(X_INIT / SCALE);
      xs <= SW'(X_INIT % SCALE);
      sy <= '0;
      ys <= '0;
    end else begin
      h  <= h_nxt;
      v  <= v_nxt;
      sx <= sx_nxt;
      xs <= xs_nxt;
      sy <= sy_nxt;
      ys <= ys_nxt;
    end
  end

endmodule

module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int H_SYNC_POL = 0,
  parameter int V_SYNC_POL = 0,
  parameter int CLK_DIV    = 1,
  parameter int SCALE      = 2,
  parameter int PREFETCH   = 8,
  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW        = $clog2(H_TOTAL),
  localparam int VW        = $clog2(V_TOTAL),
  localparam int SXW       = (H_ACTIVE / SCALE > 1) ? $clog2(H_ACTIVE / SCALE) : 1,
  localparam int SYW       = (V_ACTIVE / SCALE > 1) ? $clog2(V_ACTIVE / SCALE) : 1
) (
  input  logic           clk,
  input  logic           reset,
  output logic           pix_ce,
  output logic [HW-1:0]  h_count,
  output logic [VW-1:0]  v_count,
  output logic           hsync,
  output logic           vsync,
  output logic           video_on,
  output logic           h_blank,
  output logic           v_blank,
  output logic           line_start,
  output logic           frame_start,
  output logic [SXW-1:0] src_x,
  output logic [SYW-1:0] src_y,
  output logic           fetch_req,
  output logic [SXW-1:0] fetch_x,
  output logic [SYW-1:0] fetch_y
);

  localparam int   DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int   HS_START = H_ACTIVE + H_FP;
  localparam int   HS_END   = HS_START + H_SYNC;
  localparam int   VS_START = V_ACTIVE + V_FP;
  localparam int   VS_END   = VS_START + V_SYNC;
  localparam logic HS_ON    = (H_SYNC_POL != 0);
  localparam logic VS_ON    = (V_SYNC_POL != 0);

  logic [DW-1:0] div, div_nxt;
  logic [HW-1:0] h_nxt, fh, fh_nxt;
  logic [VW-1:0] v_nxt, fv, fv_nxt;
  logic          line_wrap, frame_wrap, f_col_start;
  logic          b_col_start, f_line_wrap, f_frame_wrap;
  logic          hs_act, vs_act, h_act, v_act, fetch_due;
  logic          unused_ok;

  assign div_nxt = (int'(div) == CLK_DIV - 1) ? '0 : div + 1'b1;

  vga_scan_pos #(
    .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE),
    .SCALE(SCALE), .H_INIT(0), .HW(HW), .VW(VW), .SXW(SXW), .SYW(SYW)
  ) u_beam (
    .clk(clk), .reset(reset), .step(pix_ce),
    .h(h_count), .v(v_count), .sx(src_x), .sy(src_y),
    .h_nxt(h_nxt), .v_nxt(v_nxt), .col_start(b_col_start),
    .line_wrap(line_wrap), .frame_wrap(frame_wrap)
  );

  vga_scan_pos #(
    .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE),
    .SCALE(SCALE), .H_INIT(PREFETCH), .HW(HW), .VW(VW), .SXW(SXW), .SYW(SYW)
  ) u_fetch (
    .clk(clk), .reset(reset), .step(pix_ce),
    .h(fh), .v(fv), .sx(fetch_x), .sy(fetch_y),
    .h_nxt(fh_nxt), .v_nxt(fv_nxt), .col_start(f_col_start),
    .line_wrap(f_line_wrap), .frame_wrap(f_frame_wrap)
  );

  assign unused_ok = ^{fh, fv, f_line_wrap, f_frame_wrap, b_col_start};

  // Decodes look at the next position so the registered flags line up with the registered counters.
  assign h_act     = int'(h_nxt) < H_ACTIVE;
  assign v_act     = int'(v_nxt) < V_ACTIVE;
  assign hs_act    = (int'(h_nxt) >= HS_START) && (int'(h_nxt) < HS_END);
  assign vs_act    = (int'(v_nxt) >= VS_START) && (int'(v_nxt) < VS_END);
  assign fetch_due = pix_ce && f_col_start && (int'(fh_nxt) < H_ACTIVE) && (int'(fv_nxt) < V_ACTIVE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div         <= '0;
      pix_ce      <= (CLK_DIV == 1);
      hsync       <= ~HS_ON;
      vsync       <= ~VS_ON;
      video_on    <= 1'b1;
      h_blank     <= 1'b0;
      v_blank     <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      fetch_req   <= 1'b0;
    end else begin
      div         <= div_nxt;
      pix_ce      <= (int'(div_nxt) == CLK_DIV - 1);
      hsync       <= hs_act ? HS_ON : ~HS_ON;
      vsync       <= vs_act ? VS_ON : ~VS_ON;
      video_on    <= h_act && v_act;
      h_blank     <= ~h_act;
      v_blank     <= ~v_act;
      line_start  <= line_wrap;
      frame_start <= frame_wrap;
      fetch_req   <= fetch_due;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two configurations checked against an arithmetic raster model,
// plus a directed vector table, async reset checks and pulse-period measurements.

module tb_vga_timing_gen;

  typedef struct {
    int ha, hfp, hs, hbp, va, vfp, vs, vbp, hpol, vpol, div, scale, pf;
  } cfg_t;

  typedef struct {
    int pix_ce, h, v, hsync, vsync, video_on, h_blank, v_blank, ls, fs, sx, sy, freq, fx, fy;
  } exp_t;

  typedef struct {
    int clks, h, v, hsync, vsync, video_on, ls, fs, freq, fx, fy;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // DUT a: tiny timing, SCALE=1, PREFETCH=1, CLK_DIV=1, active-low syncs.
  logic       a_pix_ce, a_hsync, a_vsync, a_video_on, a_h_blank, a_v_blank;
  logic       a_line_start, a_frame_start, a_fetch_req;
  logic [3:0] a_h_count;
  logic [2:0] a_v_count, a_src_x, a_fetch_x;
  logic [1:0] a_src_y, a_fetch_y;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_SYNC_POL(0), .V_SYNC_POL(0), .CLK_DIV(1), .SCALE(1), .PREFETCH(1)
  ) dut_a (
    .clk(clk), .reset(rst), .pix_ce(a_pix_ce), .h_count(a_h_count), .v_count(a_v_count),
    .hsync(a_hsync), .vsync(a_vsync), .video_on(a_video_on), .h_blank(a_h_blank),
    .v_blank(a_v_blank), .line_start(a_line_start), .frame_start(a_frame_start),
    .src_x(a_src_x), .src_y(a_src_y), .fetch_req(a_fetch_req),
    .fetch_x(a_fetch_x), .fetch_y(a_fetch_y)
  );

  // DUT b: SCALE=2, PREFETCH=5, CLK_DIV=3, active-high syncs.
  logic       b_pix_ce, b_hsync, b_vsync, b_video_on, b_h_blank, b_v_blank;
  logic       b_line_start, b_frame_start, b_fetch_req;
  logic [4:0] b_h_count;
  logic [3:0] b_v_count;
  logic [2:0] b_src_x, b_fetch_x;
  logic [1:0] b_src_y, b_fetch_y;

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_SYNC_POL(1), .V_SYNC_POL(1), .CLK_DIV(3), .SCALE(2), .PREFETCH(5)
  ) dut_b (
    .clk(clk), .reset(rst), .pix_ce(b_pix_ce), .h_count(b_h_count), .v_count(b_v_count),
    .hsync(b_hsync), .vsync(b_vsync), .video_on(b_video_on), .h_blank(b_h_blank),
    .v_blank(b_v_blank), .line_start(b_line_start), .frame_start(b_frame_start),
    .src_x(b_src_x), .src_y(b_src_y), .fetch_req(b_fetch_req),
    .fetch_x(b_fetch_x), .fetch_y(b_fetch_y)
  );

  int   checks = 0;
  int   errors = 0;
  cfg_t cfg_a, cfg_b;
  int   pa, ka, pb, kb;
  vec_t tbl[12];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: beam position p pixels after reset, k clocks into that pixel.
  function automatic exp_t model(input cfg_t c, input int p, input int k);
    exp_t e;
    int ht, vt, h, v, q, fh, fv, first;
    ht = c.ha + c.hfp + c.hs + c.hbp;
    vt = c.va + c.vfp + c.vs + c.vbp;
    h  = p % ht;
    v  = (p / ht) % vt;
    q  = p + c.pf;
    fh = q % ht;
    fv = (q / ht) % vt;
    first = (k == 0 && p > 0) ? 1 : 0;
    e.pix_ce   = (k == c.div - 1) ? 1 : 0;
    e.h        = h;
    e.v        = v;
    e.hsync    = (h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hs) ? c.hpol : 1 - c.hpol;
    e.vsync    = (v >= c.va + c.vfp && v < c.va + c.vfp + c.vs) ? c.vpol : 1 - c.vpol;
    e.video_on = (h < c.ha && v < c.va) ? 1 : 0;
    e.h_blank  = (h >= c.ha) ? 1 : 0;
    e.v_blank  = (v >= c.va) ? 1 : 0;
    e.ls       = (first == 1 && h == 0) ? 1 : 0;
    e.fs       = (first == 1 && h == 0 && v == 0) ? 1 : 0;
    e.sx       = ((h < c.ha) ? h : c.ha - 1) / c.scale;
    e.sy       = ((v < c.va) ? v : c.va - 1) / c.scale;
    e.freq     = (first == 1 && fh < c.ha && fh % c.scale == 0 && fv < c.va) ? 1 : 0;
    e.fx       = ((fh < c.ha) ? fh : c.ha - 1) / c.scale;
    e.fy       = ((fv < c.va) ? fv : c.va - 1) / c.scale;
    return e;
  endfunction

  function automatic exp_t sample_a();
    exp_t s;
    s.pix_ce = int'(a_pix_ce);  s.h = int'(a_h_count); s.v = int'(a_v_count);
    s.hsync = int'(a_hsync);    s.vsync = int'(a_vsync); s.video_on = int'(a_video_on);
    s.h_blank = int'(a_h_blank); s.v_blank = int'(a_v_blank);
    s.ls = int'(a_line_start);  s.fs = int'(a_frame_start);
    s.sx = int'(a_src_x);       s.sy = int'(a_src_y);
    s.freq = int'(a_fetch_req); s.fx = int'(a_fetch_x); s.fy = int'(a_fetch_y);
    return s;
  endfunction

  function automatic exp_t sample_b();
    exp_t s;
    s.pix_ce = int'(b_pix_ce);  s.h = int'(b_h_count); s.v = int'(b_v_count);
    s.hsync = int'(b_hsync);    s.vsync = int'(b_vsync); s.video_on = int'(b_video_on);
    s.h_blank = int'(b_h_blank); s.v_blank = int'(b_v_blank);
    s.ls = int'(b_line_start);  s.fs = int'(b_frame_start);
    s.sx = int'(b_src_x);       s.sy = int'(b_src_y);
    s.freq = int'(b_fetch_req); s.fx = int'(b_fetch_x); s.fy = int'(b_fetch_y);
    return s;
  endfunction

  task automatic compare(input string tag, input exp_t a, input exp_t e, input int p);
    check({tag, "_pix_ce"},   a.pix_ce,   e.pix_ce);
    check({tag, "_h"},        a.h,        e.h);
    check({tag, "_v"},        a.v,        e.v);
    check({tag, "_hsync"},    a.hsync,    e.hsync);
    check({tag, "_vsync"},    a.vsync,    e.vsync);
    check({tag, "_video_on"}, a.video_on, e.video_on);
    check({tag, "_h_blank"},  a.h_blank,  e.h_blank);
    check({tag, "_v_blank"},  a.v_blank,  e.v_blank);
    check({tag, "_line_st"},  a.ls,       e.ls);
    check({tag, "_frame_st"}, a.fs,       e.fs);
    check({tag, "_fetch_req"}, a.freq,    e.freq);
    if (e.video_on == 1) begin
      check({tag, "_src_x"}, a.sx, e.sx);
      check({tag, "_src_y"}, a.sy, e.sy);
    end
    if (e.freq == 1 || p == 0) begin
      check({tag, "_fetch_x"}, a.fx, e.fx);
      check({tag, "_fetch_y"}, a.fy, e.fy);
    end
  endtask

  task automatic compare_both(input string tag);
    compare({tag, "_a"}, sample_a(), model(cfg_a, pa, ka), pa);
    compare({tag, "_b"}, sample_b(), model(cfg_b, pb, kb), pb);
  endtask

  // Raise reset between clock edges, verify it acts with no edge, hold, release on a falling edge.
  task automatic do_reset(input int hold);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    pa = 0; ka = 0; pb = 0; kb = 0;
    compare_both("async_rst");
    repeat (hold) @(negedge clk);
    compare_both("rst_hold");
    rst = 1'b0;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ka++;
      if (ka == cfg_a.div) begin ka = 0; pa++; end
      kb++;
      if (kb == cfg_b.div) begin kb = 0; pb++; end
      compare_both("run");
    end
  endtask

  function automatic int sig(input int sel);
    case (sel)
      0:       return int'(a_line_start);
      1:       return int'(a_frame_start);
      2:       return int'(b_line_start);
      3:       return int'(b_frame_start);
      4:       return int'(b_fetch_req);
      default: return int'(b_pix_ce);
    endcase
  endfunction

  task automatic measure(input string name, input int sel, input int expected, input int budget);
    int n;
    n = 0;
    while (sig(sel) == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_seen"}, sig(sel), 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sig(sel) == 0 && n < budget);
    check({name, "_period"}, n, expected);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cur;
    cfg_a = '{8, 1, 2, 1, 4, 1, 1, 1, 0, 0, 1, 1, 1};
    cfg_b = '{16, 2, 3, 3, 8, 1, 2, 1, 1, 1, 3, 2, 5};

    // clks after release: h, v, hsync, vsync, video_on, line_start, frame_start, fetch_req, fetch_x, fetch_y
    tbl[0]  = '{0,  0,  0, 1, 1, 1, 0, 0, 0, 1, 0};
    tbl[1]  = '{7,  7,  0, 1, 1, 1, 0, 0, 0, 0, 0};
    tbl[2]  = '{8,  8,  0, 1, 1, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{9,  9,  0, 0, 1, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{10, 10, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{11, 11, 0, 1, 1, 0, 0, 0, 1, 0, 1};
    tbl[6]  = '{12, 0,  1, 1, 1, 1, 1, 0, 1, 1, 1};
    tbl[7]  = '{13, 1,  1, 1, 1, 1, 0, 0, 1, 2, 1};
    tbl[8]  = '{48, 0,  4, 1, 1, 0, 1, 0, 0, 0, 0};
    tbl[9]  = '{60, 0,  5, 1, 0, 0, 1, 0, 0, 0, 0};
    tbl[10] = '{83, 11, 6, 1, 1, 0, 0, 0, 1, 0, 0};
    tbl[11] = '{84, 0,  0, 1, 1, 1, 1, 1, 1, 1, 0};

    do_reset(2);
    cur = 0;
    for (int i = 0; i < 12; i++) begin
      repeat (tbl[i].clks - cur) @(negedge clk);
      cur = tbl[i].clks;
      check("vec_h",        int'(a_h_count),     tbl[i].h);
      check("vec_v",        int'(a_v_count),     tbl[i].v);
      check("vec_hsync",    int'(a_hsync),       tbl[i].hsync);
      check("vec_vsync",    int'(a_vsync),       tbl[i].vsync);
      check("vec_video_on", int'(a_video_on),    tbl[i].video_on);
      check("vec_line_st",  int'(a_line_start),  tbl[i].ls);
      check("vec_frame_st", int'(a_frame_start), tbl[i].fs);
      check("vec_fetch",    int'(a_fetch_req),   tbl[i].freq);
      if (tbl[i].freq == 1 || tbl[i].clks == 0) begin
        check("vec_fetch_x", int'(a_fetch_x), tbl[i].fx);
        check("vec_fetch_y", int'(a_fetch_y), tbl[i].fy);
      end
    end

    // Mid-frame reset, then several frames of both configurations against the model.
    do_reset(3);
    run_cycles(41);
    do_reset(3);
    run_cycles(3000);

    for (int it = 0; it < 6; it++) begin
      run_cycles(int'($urandom_range(200, 1500)));
      do_reset(int'($urandom_range(1, 4)));
    end
    run_cycles(900);

    // Pulse spacing from a fresh reset.
    do_reset(1);
    measure("b_fetch_gap",   4, 6,   200);
    measure("b_pix_ce_gap",  5, 3,   20);
    measure("a_line_period", 0, 12,  100);
    measure("a_frame_period", 1, 84, 300);
    measure("b_line_period", 2, 72,  300);
    measure("b_frame_period", 3, 864, 2000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
